// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry and helpers.
//   H_ACTIVE / V_ACTIVE  visible raster size in pixels
//   CELL_LOG2            log2 of the square cell edge
//   GRID_W / GRID_H      cells per row / per column
//   ADDR_W               framebuffer cell address width
//   rgb_t                24-bit {r,g,b} pixel
//   cell_addr()          raster (x,y) to cell address, shared with the write side
package fb_pkg;

    localparam int COORD_W   = 11;
    localparam int CELL_LOG2 = 4;
    localparam int CELL_EDGE = 1 << CELL_LOG2;
    localparam int GRID_W    = 40;
    localparam int GRID_H    = 30;
    localparam int ADDR_W    = 11;

    localparam logic [COORD_W-1:0] H_ACTIVE = 11'd640;
    localparam logic [COORD_W-1:0] V_ACTIVE = 11'd480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // cy*40 + cx built from two shifts so no multiplier is inferred.
    // The shift amounts are tied to GRID_W = 40 = 32 + 8.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        logic [ADDR_W-1:0] cx;
        logic [ADDR_W-1:0] cy;
        cx = ADDR_W'(x >> CELL_LOG2);
        cy = ADDR_W'(y >> CELL_LOG2);
        return (cy << 5) + (cy << 3) + cx;
    endfunction

endpackage

// File: rtl/fb_scan_reader_if.sv
// fb_scan_reader_if: framebuffer read port.
//   fb_rd_en    read strobe            (master -> slave)
//   fb_rd_addr  cell address           (master -> slave)
//   fb_rd_data  {R,G,B}, one clock after the registered request (slave -> master)
interface fb_scan_reader_if;
    import fb_pkg::*;

    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_rd_addr;
    logic [23:0]       fb_rd_data;

    modport master (output fb_rd_en, output fb_rd_addr, input fb_rd_data);
    modport slave  (input fb_rd_en, input fb_rd_addr, output fb_rd_data);

endinterface

// File: rtl/fb_blink_timer.sv
// fb_blink_timer: frame-start detection and cursor blink phase.
//   CLOCK_50     system clock
//   reset        asynchronous, active-low
//   x_coord      raster x
//   y_coord      raster y
//   frame_start  one-clock pulse when the raster arrives at (0,0)
//   blink_on     cursor visible phase, toggles every BLINK_FRAMES frames
module fb_blink_timer
    import fb_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [COORD_W-1:0] x_coord,
    input  logic [COORD_W-1:0] y_coord,
    output logic               frame_start,
    output logic               blink_on
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic             origin;
    logic             prev_origin;
    logic [CNT_W-1:0] frame_cnt;

    assign origin = (x_coord == '0) && (y_coord == '0);

    // prev_origin resets high so coordinates parked at (0,0) during and
    // after reset do not produce a spurious frame_start.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            prev_origin <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            prev_origin <= origin;
            frame_start <= origin && !prev_origin;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fb_scan_reader.sv
// fb_scan_reader: framebuffer read side with blinking cursor overlay.
// Three-stage pipeline, one pixel per clock, fixed latency of 3 edges:
//   edge 1  register read request plus valid/cursor-hit sideband
//   edge 2  RAM registers fb_rd_data
//   edge 3  register top_R/G/B (inverted inside the visible cursor box)
// Ports:
//   CLOCK_50             system clock
//   reset                asynchronous, active-low
//   x_coord, y_coord     raster position from the vga block
//   cursor_x, cursor_y   cursor box top-left in pixels
//   cursor_en            enable cursor overlay
//   fb                   framebuffer read port (master)
//   top_R, top_G, top_B  pixel colour toward the vga block
//   frame_start          one-clock pulse at the start of each frame
module fb_scan_reader
    import fb_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [COORD_W-1:0]      x_coord,
    input  logic [COORD_W-1:0]      y_coord,
    input  logic [COORD_W-1:0]      cursor_x,
    input  logic [COORD_W-1:0]      cursor_y,
    input  logic                    cursor_en,
    fb_scan_reader_if.master        fb,
    output logic [7:0]              top_R,
    output logic [7:0]              top_G,
    output logic [7:0]              top_B,
    output logic                    frame_start
);

    logic          active;
    logic          hit;
    logic [11:0]   cur_x_end;
    logic [11:0]   cur_y_end;
    logic          v1, h1, v2, h2;
    logic          blink_on;
    rgb_t          pix_next;

    assign active = (x_coord < H_ACTIVE) && (y_coord < V_ACTIVE);

    // Box ends computed one bit wider so a cursor near the right/bottom
    // edge never wraps around onto column/row 0.
    assign cur_x_end = {1'b0, cursor_x} + 12'(CELL_EDGE);
    assign cur_y_end = {1'b0, cursor_y} + 12'(CELL_EDGE);
    assign hit = (x_coord >= cursor_x) && ({1'b0, x_coord} < cur_x_end) &&
                 (y_coord >= cursor_y) && ({1'b0, y_coord} < cur_y_end);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            fb.fb_rd_en   <= 1'b0;
            fb.fb_rd_addr <= '0;
            v1            <= 1'b0;
            h1            <= 1'b0;
            v2            <= 1'b0;
            h2            <= 1'b0;
        end else begin
            fb.fb_rd_en   <= active;
            fb.fb_rd_addr <= cell_addr(x_coord, y_coord);
            v1            <= active;
            h1            <= hit;
            v2            <= v1;
            h2            <= h1;
        end
    end

    // cursor_en and blink_on are sampled at the output stage, not
    // carried down the pipe.
    always_comb begin
        pix_next = '0;
        if (v2) begin
            if (h2 && cursor_en && blink_on) begin
                pix_next = rgb_t'(~fb.fb_rd_data);
            end else begin
                pix_next = rgb_t'(fb.fb_rd_data);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            top_R <= '0;
            top_G <= '0;
            top_B <= '0;
        end else begin
            top_R <= pix_next.r;
            top_G <= pix_next.g;
            top_B <= pix_next.b;
        end
    end

    fb_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .frame_start (frame_start),
        .blink_on    (blink_on)
    );

endmodule

// File: tb/tb_fb_scan_reader.sv
// tb_fb_scan_reader: self-checking bench for fb_scan_reader with a
// behavioural synchronous-read RAM and a latency scoreboard.
module tb_fb_scan_reader;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [10:0] x_coord, y_coord, cursor_x, cursor_y;
    logic        cursor_en;
    logic [7:0]  top_R, top_G, top_B;
    logic        frame_start;

    fb_scan_reader_if bus ();

    fb_scan_reader #(.BLINK_FRAMES(2)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .cursor_en   (cursor_en),
        .fb          (bus),
        .top_R       (top_R),
        .top_G       (top_G),
        .top_B       (top_B),
        .frame_start (frame_start)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [23:0] mem [0:2047];

    always @(posedge CLOCK_50) begin
        if (bus.fb_rd_en) bus.fb_rd_data <= mem[bus.fb_rd_addr];
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        bit          chk;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [10:0] x, y, cx, cy;
        logic        cen;
        logic        exp_en;
        logic [10:0] exp_addr;
        logic [23:0] exp_rgb;
    } vec_t;
    vec_t vecs[12];

    // Blink model state
    int fcnt    = 0;
    bit blink_m = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLOCK_50) begin
        sb_t e;
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.chk) check("pixel", {8'h0, top_R, top_G, top_B}, {8'h0, e.rgb});
        end
    end

    // Present coords at the falling edge, return 1ns after the next rising edge.
    task automatic drive(input logic [10:0] x, input logic [10:0] y,
                         input bit push, input bit chk, input logic [23:0] exp);
        sb_t e;
        @(negedge CLOCK_50);
        x_coord = x;
        y_coord = y;
        if (push) begin
            e.due = cyc + 3;
            e.rgb = exp;
            e.chk = chk;
            sb.push_back(e);
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic gen_frame();
        drive(11'd5, 11'd5, 0, 0, 24'h0);
        drive(11'd0, 11'd0, 0, 0, 24'h0);
        check("frame_start_pulse", {31'h0, frame_start}, 32'd1);
        drive(11'd5, 11'd5, 0, 0, 24'h0);
        check("frame_start_one_clk", {31'h0, frame_start}, 32'd0);
        fcnt++;
        if (fcnt == 2) begin
            fcnt    = 0;
            blink_m = !blink_m;
        end
    endtask

    // Hold a cursor-cell pixel (data 0) and compare against the blink model.
    task automatic check_blink_pixel();
        logic [23:0] exp;
        exp = (cursor_en && blink_m) ? 24'hFFFFFF : 24'h000000;
        for (int i = 0; i < 4; i++) drive(11'd310, 11'd240, 1, (i < 2), exp);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 24'h0;
        mem[0]    = 24'hABCDEF;
        mem[39]   = 24'h0A0B0C;
        mem[81]   = 24'h006400;
        mem[1199] = 24'h123456;
        bus.fb_rd_data = 24'h0;

        reset     = 1'b0;
        x_coord   = 11'd0;
        y_coord   = 11'd0;
        cursor_x  = 11'd304;
        cursor_y  = 11'd232;
        cursor_en = 1'b1;

        //               x    y    cx   cy  cen en  addr   rgb
        vecs[0]  = '{ 17,  33, 304, 232, 1, 1,   81, 24'h006400};
        vecs[1]  = '{639, 479, 304, 232, 1, 1, 1199, 24'h123456};
        vecs[2]  = '{640,  10, 304, 232, 1, 0,   40, 24'h000000};
        vecs[3]  = '{700,  33, 304, 232, 1, 0,  123, 24'h000000};
        vecs[4]  = '{310, 240, 304, 232, 1, 1,  619, 24'hFFFFFF};
        vecs[5]  = '{320, 240, 304, 232, 1, 1,  620, 24'h000000};
        vecs[6]  = '{310, 240, 304, 232, 0, 1,  619, 24'h000000};
        vecs[7]  = '{303, 240, 304, 232, 1, 1,  618, 24'h000000};
        vecs[8]  = '{319, 247, 304, 232, 1, 1,  619, 24'hFFFFFF};
        vecs[9]  = '{310, 248, 304, 232, 1, 1,  619, 24'h000000};
        vecs[10] = '{639,   5, 632,   0, 1, 1,   39, 24'hF5F4F3};
        vecs[11] = '{  0,   5, 632,   0, 1, 1,    0, 24'hABCDEF};

        // Reset held while coordinates sweep: everything stays at 0.
        drive(11'd0,   11'd0,   0, 0, 24'h0);
        drive(11'd17,  11'd33,  0, 0, 24'h0);
        drive(11'd639, 11'd479, 0, 0, 24'h0);
        drive(11'd0,   11'd0,   0, 0, 24'h0);
        check("rst_rgb", {8'h0, top_R, top_G, top_B}, 32'h0);
        check("rst_rd_en", {31'h0, bus.fb_rd_en}, 32'h0);
        check("rst_rd_addr", {21'h0, bus.fb_rd_addr}, 32'h0);
        check("rst_frame_start", {31'h0, frame_start}, 32'h0);

        // Release at origin: no pulse until the raster leaves and returns.
        @(negedge CLOCK_50);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(11'd0, 11'd0, 0, 0, 24'h0);
            check("no_fs_at_origin", {31'h0, frame_start}, 32'h0);
        end
        gen_frame();

        // Table vectors: first two of each four held clocks are checked.
        for (int v = 0; v < 12; v++) begin
            cursor_x  = vecs[v].cx;
            cursor_y  = vecs[v].cy;
            cursor_en = vecs[v].cen;
            for (int i = 0; i < 4; i++) begin
                drive(vecs[v].x, vecs[v].y, 1, (i < 2), vecs[v].exp_rgb);
                if (i == 0) begin
                    check("rd_en", {31'h0, bus.fb_rd_en}, {31'h0, vecs[v].exp_en});
                    check("rd_addr", {21'h0, bus.fb_rd_addr}, {21'h0, vecs[v].exp_addr});
                end
            end
        end
        for (int i = 0; i < 4; i++) drive(11'd700, 11'd500, 0, 0, 24'h0);

        // Reset in the middle of a valid pixel stream.
        cursor_x  = 11'd304;
        cursor_y  = 11'd232;
        cursor_en = 1'b1;
        for (int i = 0; i < 4; i++) drive(11'd17, 11'd33, 0, 0, 24'h0);
        check("pre_reset_pixel", {8'h0, top_R, top_G, top_B}, 32'h006400);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_rgb", {8'h0, top_R, top_G, top_B}, 32'h0);
        check("async_rst_rd_en", {31'h0, bus.fb_rd_en}, 32'h0);
        for (int i = 0; i < 3; i++) drive(11'd700, 11'd500, 0, 0, 24'h0);
        @(negedge CLOCK_50);
        reset = 1'b1;
        drive(11'd700, 11'd500, 0, 0, 24'h0);
        drive(11'd17, 11'd33, 0, 0, 24'h0);
        check("post_rst_e1_rgb", {8'h0, top_R, top_G, top_B}, 32'h0);
        check("post_rst_e1_addr", {21'h0, bus.fb_rd_addr}, 32'd81);
        drive(11'd17, 11'd33, 0, 0, 24'h0);
        check("post_rst_e2_rgb", {8'h0, top_R, top_G, top_B}, 32'h0);
        drive(11'd17, 11'd33, 0, 0, 24'h0);
        check("post_rst_e3_rgb", {8'h0, top_R, top_G, top_B}, 32'h006400);
        fcnt    = 0;
        blink_m = 1'b1;

        // Blink with a 2-frame half-period; cursor_en low does not stop the count.
        gen_frame();
        check_blink_pixel();
        gen_frame();
        check_blink_pixel();
        cursor_en = 1'b0;
        gen_frame();
        check_blink_pixel();
        cursor_en = 1'b1;
        gen_frame();
        check_blink_pixel();

        for (int i = 0; i < 5; i++) drive(11'd700, 11'd500, 0, 0, 24'h0);
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
